// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control stage: main-control class codes,
// ALU operation codes and the multi-cycle sequencer state.
package alu_ctrl_pkg;

   localparam logic [2:0] ALUOP_R  = 3'b000;
   localparam logic [2:0] ALUOP_I  = 3'b001;
   localparam logic [2:0] ALUOP_U  = 3'b010;
   localparam logic [2:0] ALUOP_LS = 3'b011;
   localparam logic [2:0] ALUOP_B  = 3'b100;

   localparam logic [4:0] OP_ADD    = 5'h00;
   localparam logic [4:0] OP_SUB    = 5'h01;
   localparam logic [4:0] OP_OR     = 5'h02;
   localparam logic [4:0] OP_SLL    = 5'h03;
   localparam logic [4:0] OP_SRL    = 5'h04;
   localparam logic [4:0] OP_LUI    = 5'h05;
   localparam logic [4:0] OP_AND    = 5'h06;
   localparam logic [4:0] OP_XOR    = 5'h07;
   localparam logic [4:0] OP_BEQ    = 5'h08;
   localparam logic [4:0] OP_BNE    = 5'h09;
   localparam logic [4:0] OP_BLT    = 5'h0A;
   localparam logic [4:0] OP_BGE    = 5'h0B;
   localparam logic [4:0] OP_SRA    = 5'h0C;
   localparam logic [4:0] OP_SLT    = 5'h0D;
   localparam logic [4:0] OP_SLTU   = 5'h0E;
   localparam logic [4:0] OP_BLTU   = 5'h0F;
   localparam logic [4:0] OP_BGEU   = 5'h10;
   localparam logic [4:0] OP_MUL    = 5'h11;

   typedef enum logic {ST_RUN = 1'b0, ST_MC_WAIT = 1'b1} state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {funct7, class, funct3} into an ALU op code plus
// illegal / multiply / divide flags.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter int ALU_OP_W = 5,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [6:0]          funct7_i,
   input  logic [2:0]          alu_op_i,
   input  logic [2:0]          funct3_i,
   output logic [ALU_OP_W-1:0] op_o,
   output logic                illegal_o,
   output logic                is_mul_o,
   output logic                is_div_o
);

   logic [4:0] code;
   logic       ill;

   always_comb begin
      code     = OP_ADD;
      ill      = 1'b0;
      is_mul_o = 1'b0;
      is_div_o = 1'b0;
      case (alu_op_i)
         ALUOP_R: begin
            if (funct7_i == 7'h00) begin
               case (funct3_i)
                  3'b000:  code = OP_ADD;
                  3'b001:  code = OP_SLL;
                  3'b010:  code = OP_SLT;
                  3'b011:  code = OP_SLTU;
                  3'b100:  code = OP_XOR;
                  3'b101:  code = OP_SRL;
                  3'b110:  code = OP_OR;
                  default: code = OP_AND;
               endcase
            end else if (funct7_i == 7'h20 && funct3_i == 3'b000) begin
               code = OP_SUB;
            end else if (funct7_i == 7'h20 && funct3_i == 3'b101) begin
               code = OP_SRA;
            end else if (funct7_i == 7'h01 && ENABLE_M) begin
               // M ops are contiguous from MUL; funct3[2] splits mul from div
               code     = OP_MUL + {2'b00, funct3_i};
               is_mul_o = ~funct3_i[2];
               is_div_o = funct3_i[2];
            end else begin
               ill = 1'b1;
            end
         end
         ALUOP_I: begin
            case (funct3_i)
               3'b000:  code = OP_ADD;
               3'b010:  code = OP_SLT;
               3'b011:  code = OP_SLTU;
               3'b100:  code = OP_XOR;
               3'b110:  code = OP_OR;
               3'b111:  code = OP_AND;
               3'b001: begin
                  code = OP_SLL;
                  ill  = (funct7_i != 7'h00);
               end
               default: begin
                  if (funct7_i == 7'h00)      code = OP_SRL;
                  else if (funct7_i == 7'h20) code = OP_SRA;
                  else                        ill  = 1'b1;
               end
            endcase
         end
         ALUOP_U:  code = OP_LUI;
         ALUOP_LS: code = OP_ADD;
         ALUOP_B: begin
            case (funct3_i)
               3'b000:  code = OP_BEQ;
               3'b001:  code = OP_BNE;
               3'b100:  code = OP_BLT;
               3'b101:  code = OP_BGE;
               3'b110:  code = OP_BLTU;
               3'b111:  code = OP_BGEU;
               default: ill  = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase
      if (ill) code = OP_ADD;
   end

   assign op_o      = ALU_OP_W'(code);
   assign illegal_o = ill;

endmodule

// File: rtl/alu_control_seq.sv
// ID/EX ALU control register stage with a start/count/busy sequencer that
// holds EX for the latency of multi-cycle multiply and divide operations.
module alu_control_seq
   import alu_ctrl_pkg::*;
#(
   parameter int ALU_OP_W    = 5,
   parameter bit ENABLE_M    = 1'b1,
   parameter int MUL_LATENCY = 3,
   parameter int DIV_LATENCY = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_i,
   input  logic [6:0]          funct7_i,
   input  logic [2:0]          alu_op_i,
   input  logic [2:0]          funct3_i,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic [ALU_OP_W-1:0] alu_operation_o,
   output logic                valid_o,
   output logic                illegal_o,
   output logic                mdu_start_o,
   output logic                busy_o,
   output logic                mc_done_o
);

   localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);
   localparam bit MUL_ONE = (MUL_LATENCY == 1);
   localparam bit DIV_ONE = (DIV_LATENCY == 1);

   logic [ALU_OP_W-1:0] dec_op;
   logic                dec_ill, dec_mul, dec_div;

   alu_op_decode #(.ALU_OP_W(ALU_OP_W), .ENABLE_M(ENABLE_M)) u_dec (
      .funct7_i  (funct7_i),
      .alu_op_i  (alu_op_i),
      .funct3_i  (funct3_i),
      .op_o      (dec_op),
      .illegal_o (dec_ill),
      .is_mul_o  (dec_mul),
      .is_div_o  (dec_div)
   );

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ALU_OP_W-1:0] op_q, op_d;
   logic                valid_q, valid_d, ill_q, ill_d;
   logic                start_q, start_d, lat1_q, lat1_d;
   logic                latch, dec_mc, dec_lat1;

   assign dec_mc   = valid_i & ~flush_i & (dec_mul | dec_div);
   assign dec_lat1 = dec_mul ? MUL_ONE : DIV_ONE;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      valid_d = valid_q;
      ill_d   = ill_q;
      start_d = 1'b0;
      lat1_d  = lat1_q;
      latch   = 1'b0;
      if (state_q == ST_RUN) begin
         latch = ~stall_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         latch = ~stall_i;
      end
      // leaving MC_WAIT and accepting the next ID instruction share one edge
      if (latch) begin
         op_d    = valid_i ? dec_op : '0;
         ill_d   = valid_i & dec_ill;
         valid_d = valid_i & ~flush_i;
         start_d = dec_mc;
         lat1_d  = dec_mc & dec_lat1;
         cnt_d   = dec_mc ? (dec_mul ? MUL_CNT : DIV_CNT) : '0;
         state_d = (dec_mc && !dec_lat1) ? ST_MC_WAIT : ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
         ill_q   <= 1'b0;
         start_q <= 1'b0;
         lat1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         valid_q <= valid_d;
         ill_q   <= ill_d;
         start_q <= start_d;
         lat1_q  <= lat1_d;
      end
   end

   assign alu_operation_o = op_q;
   assign valid_o         = valid_q;
   assign illegal_o       = ill_q;
   assign mdu_start_o     = start_q;
   assign busy_o          = (state_q == ST_MC_WAIT) && (cnt_q != '0 || stall_i);
   // single-cycle ops never enter MC_WAIT, so their result is ready with the start pulse
   assign mc_done_o       = ((state_q == ST_MC_WAIT) && cnt_q == '0) || (start_q && lat1_q);

endmodule

// File: tb/tb_alu_control_seq.sv
// Three parameterisations of alu_control_seq driven from shared inputs and
// checked every cycle against an occupancy-based reference model.
module tb_alu_control_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [6:0] f7 = '0;
   logic [2:0] cls = '0, f3 = '0;

   logic [4:0] op_o[3];
   logic       vld_o[3], ill_o[3], start_o[3], busy_o[3], done_o[3];

   int checks = 0;
   int errors = 0;

   localparam bit EN_M[3]  = '{1'b1, 1'b1, 1'b0};
   localparam int MLAT[3]  = '{3, 3, 3};
   localparam int DLAT[3]  = '{4, 8, 8};
   localparam int R_TAB[8] = '{'h00, 'h03, 'h0D, 'h0E, 'h07, 'h04, 'h02, 'h06};
   localparam int B_TAB[8] = '{'h08, 'h09, -1, -1, 'h0A, 'h0B, 'h0F, 'h10};

   always #5 clk = ~clk;

   alu_control_seq #(.ALU_OP_W(5), .ENABLE_M(1'b1), .MUL_LATENCY(3), .DIV_LATENCY(4)) dut_a (
      .clk(clk), .reset(rst_n), .valid_i(valid), .funct7_i(f7), .alu_op_i(cls), .funct3_i(f3),
      .stall_i(stall), .flush_i(flush), .alu_operation_o(op_o[0]), .valid_o(vld_o[0]),
      .illegal_o(ill_o[0]), .mdu_start_o(start_o[0]), .busy_o(busy_o[0]), .mc_done_o(done_o[0]));

   alu_control_seq #(.ALU_OP_W(5), .ENABLE_M(1'b1), .MUL_LATENCY(3), .DIV_LATENCY(8)) dut_b (
      .clk(clk), .reset(rst_n), .valid_i(valid), .funct7_i(f7), .alu_op_i(cls), .funct3_i(f3),
      .stall_i(stall), .flush_i(flush), .alu_operation_o(op_o[1]), .valid_o(vld_o[1]),
      .illegal_o(ill_o[1]), .mdu_start_o(start_o[1]), .busy_o(busy_o[1]), .mc_done_o(done_o[1]));

   alu_control_seq #(.ALU_OP_W(5), .ENABLE_M(1'b0), .MUL_LATENCY(3), .DIV_LATENCY(8)) dut_c (
      .clk(clk), .reset(rst_n), .valid_i(valid), .funct7_i(f7), .alu_op_i(cls), .funct3_i(f3),
      .stall_i(stall), .flush_i(flush), .alu_operation_o(op_o[2]), .valid_o(vld_o[2]),
      .illegal_o(ill_o[2]), .mdu_start_o(start_o[2]), .busy_o(busy_o[2]), .mc_done_o(done_o[2]));

   // Reference state: what sits in EX, and how many cycles a multi-cycle op has spent there
   int m_op[3]    = '{0, 0, 0};
   bit m_vld[3]   = '{0, 0, 0};
   bit m_ill[3]   = '{0, 0, 0};
   bit m_start[3] = '{0, 0, 0};
   bit m_mc[3]    = '{0, 0, 0};
   int m_age[3]   = '{0, 0, 0};
   int m_lat[3]   = '{1, 1, 1};

   // kind: 0 plain, 1 multiply, 2 divide
   function automatic void ref_decode(input bit en_m, input int c7, input int c, input int c3,
                                      output int op, output bit ill, output int kind);
      op = -1; kind = 0;
      case (c)
         0: begin
            if (c7 == 'h00) op = R_TAB[c3];
            else if (c7 == 'h20 && c3 == 0) op = 'h01;
            else if (c7 == 'h20 && c3 == 5) op = 'h0C;
            else if (c7 == 'h01 && en_m) begin
               op = 'h11 + c3;
               kind = (c3 < 4) ? 1 : 2;
            end
         end
         1: begin
            if (c3 == 1) op = (c7 == 'h00) ? 'h03 : -1;
            else if (c3 == 5) op = (c7 == 'h00) ? 'h04 : (c7 == 'h20) ? 'h0C : -1;
            else op = R_TAB[c3];
         end
         2: op = 'h05;
         3: op = 'h00;
         4: op = B_TAB[c3];
         default: op = -1;
      endcase
      ill = (op < 0);
      if (ill) begin
         op = 0;
         kind = 0;
      end
   endfunction

   task automatic do_latch(input int k);
      int  op, kind;
      bit  ill;
      bit  mc;
      ref_decode(EN_M[k], int'(f7), int'(cls), int'(f3), op, ill, kind);
      m_op[k]    = valid ? op : 0;
      m_ill[k]   = valid && ill;
      m_vld[k]   = valid && !flush;
      mc         = valid && !flush && kind != 0;
      m_start[k] = mc;
      if (mc) begin
         m_lat[k] = (kind == 1) ? MLAT[k] : DLAT[k];
         m_mc[k]  = (m_lat[k] > 1);
         m_age[k] = 1;
      end
   endtask

   task automatic model_step(input int k);
      if (!rst_n) begin
         m_op[k] = 0; m_vld[k] = 0; m_ill[k] = 0; m_start[k] = 0; m_mc[k] = 0; m_age[k] = 0;
      end else if (m_mc[k]) begin
         m_start[k] = 0;
         if (m_age[k] < m_lat[k]) m_age[k]++;
         else if (!stall) begin
            m_mc[k] = 0;
            do_latch(k);
         end
      end else if (stall) begin
         m_start[k] = 0;
      end else begin
         do_latch(k);
      end
   endtask

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_dut(input int k);
      bit exp_busy, exp_done;
      exp_busy = m_mc[k] && (m_age[k] < m_lat[k] || stall);
      exp_done = (m_mc[k] && m_age[k] >= m_lat[k]) || (m_start[k] && m_lat[k] == 1);
      chk("op", k, 32'(op_o[k]), 32'(m_op[k]));
      chk("valid", k, 32'(vld_o[k]), 32'(m_vld[k]));
      chk("illegal", k, 32'(ill_o[k]), 32'(m_ill[k]));
      chk("start", k, 32'(start_o[k]), 32'(m_start[k]));
      chk("busy", k, 32'(busy_o[k]), 32'(exp_busy));
      chk("done", k, 32'(done_o[k]), 32'(exp_done));
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_dut(k);
   endtask

   task automatic drive(input bit v, input logic [6:0] a7, input logic [2:0] c, input logic [2:0] a3);
      valid = v; f7 = a7; cls = c; f3 = a3;
   endtask

   initial begin
      // reset
      tick(); tick();
      chk("rst_op", 0, 32'(op_o[0]), 32'h0);
      chk("rst_busy", 1, 32'(busy_o[1]), 32'h0);
      rst_n = 1'b1;

      // SRA decode
      drive(1, 7'h20, 3'b000, 3'b101);
      tick();
      chk("sra_op", 0, 32'(op_o[0]), 32'h0C);
      chk("sra_valid", 0, 32'(vld_o[0]), 32'h1);

      // DIV on dut_a (latency 4): start, 3 busy cycles, done on 4th, next op on 5th
      drive(1, 7'h01, 3'b000, 3'b100);
      tick();
      chk("div_start", 0, 32'(start_o[0]), 32'h1);
      chk("div_op", 0, 32'(op_o[0]), 32'h15);
      chk("div_ill_c", 2, 32'(ill_o[2]), 32'h1);
      drive(1, 7'h00, 3'b000, 3'b000);
      tick(); chk("div_busy2", 0, 32'(busy_o[0]), 32'h1);
      tick(); chk("div_busy3", 0, 32'(busy_o[0]), 32'h1);
      tick(); chk("div_done4", 0, 32'(done_o[0]), 32'h1);
      tick(); chk("div_next5", 0, 32'(op_o[0]), 32'h00);
      drive(0, 7'h00, 3'b000, 3'b000);
      repeat (10) tick();

      // MUL with stall at completion; dut_c sees it as illegal
      drive(1, 7'h01, 3'b000, 3'b000);
      tick();
      chk("mulc_op", 2, 32'(op_o[2]), 32'h00);
      chk("mulc_ill", 2, 32'(ill_o[2]), 32'h1);
      chk("mulc_start", 2, 32'(start_o[2]), 32'h0);
      drive(1, 7'h00, 3'b001, 3'b111);
      stall = 1'b1;
      repeat (3) tick();
      chk("stall_done", 0, 32'(done_o[0]), 32'h1);
      chk("stall_busy", 0, 32'(busy_o[0]), 32'h1);
      chk("mulc_busy", 2, 32'(busy_o[2]), 32'h0);
      stall = 1'b0;
      tick();
      chk("stall_exit", 0, 32'(op_o[0]), 32'h06);
      drive(0, 7'h00, 3'b000, 3'b000);
      repeat (10) tick();

      // Flush in RUN
      drive(1, 7'h00, 3'b000, 3'b000);
      flush = 1'b1;
      tick();
      chk("flush_valid", 0, 32'(vld_o[0]), 32'h0);
      flush = 1'b0;
      drive(0, 7'h00, 3'b000, 3'b000);
      tick();

      // Reset during MC_WAIT on dut_b (DIV latency 8, count at 5)
      drive(1, 7'h01, 3'b000, 3'b101);
      tick();
      drive(0, 7'h00, 3'b000, 3'b000);
      tick(); tick();
      chk("pre_rst_busy", 1, 32'(busy_o[1]), 32'h1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_op", 1, 32'(op_o[1]), 32'h0);
      chk("mid_rst_busy", 1, 32'(busy_o[1]), 32'h0);
      rst_n = 1'b1;
      drive(1, 7'h00, 3'b100, 3'b001);
      tick();
      chk("post_rst_bne", 1, 32'(op_o[1]), 32'h09);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         valid = ($urandom_range(0, 9) != 0);
         cls   = 3'($urandom_range(0, 7));
         f3    = 3'($urandom);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         rst_n = ($urandom_range(0, 99) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, parametrised ALU control stage for the pipelined RV32I/M core, sitting at the ID/EX boundary. It decodes {funct7, ALU_Op, funct3} into an ALU operation code and latches it with a valid bit. For multi-cycle M-extension operations, it sequences the EX occupancy with a start pulse, a down-counter and an upstream busy/stall handshake.

## Interface
- ALU_OP_W, 5, width of the operation code; must be ≥ 5.
- ENABLE_M, 1, when 0 every M-extension encoding decodes as illegal.
- MUL_LATENCY, 3, EX cycles occupied by MUL/MULH/MULHSU/MULHU; must be ≥ 1.
- DIV_LATENCY, 8, EX cycles occupied by DIV/DIVU/REM/REMU; must be ≥ 1.
- clk  in  1  core clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- valid_i  in  1  ID holds a real instruction.
- funct7_i  in  7  instruction[31:25].
- alu_op_i  in  3  class from main control: 000 R, 001 I-ALU, 010 U (LUI), 011 load/store address, 100 B.
- funct3_i  in  3  instruction[14:12].
- stall_i  in  1  downstream stall; hold EX contents.
- flush_i  in  1  kill the instruction being latched from ID.
- alu_operation_o  out  ALU_OP_W  registered operation code.
- valid_o  out  1  alu_operation_o belongs to a live instruction.
- illegal_o  out  1  latched encoding was not in the decode table.
- mdu_start_o  out  1  one-cycle pulse: the multi-cycle op enters EX.
- busy_o  out  1  EX is occupied; upstream must not advance.
- mc_done_o  out  1  multi-cycle result is valid this cycle.

## Operation
- Decode (values are hex, zero-extended to ALU_OP_W):
  - ADD 00, SUB 01, OR 02, SLL 03, SRL 04, LUI 05, AND 06, XOR 07.
  - BEQ 08, BNE 09, BLT 0A, BGE 0B.
  - SRA 0C, SLT 0D, SLTU 0E, BLTU 0F, BGEU 10.
  - MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18.
- Class 000 (R):
  - funct7 0x00 selects the base ops by funct3.
  - funct7 0x20 with funct3 000 gives SUB; with funct3 101 gives SRA.
  - funct7 0x01 gives the M ops, indexed by funct3.
- Class 001 (I-ALU):
  - funct3 selects ADD/SLT/SLTU/XOR/OR/AND.
  - SLLI requires funct7 0x00.
  - funct3 101 gives SRL for funct7 0x00 and SRA for funct7 0x20.
- Class 010 gives LUI and class 011 gives ADD, each for any funct3/funct7.
- Class 100 (B): funct3 000/001/100/101/110/111 give BEQ/BNE/BLT/BGE/BLTU/BGEU.
- Any other combination, including M ops with ENABLE_M=0, is illegal:
  - the code is forced to ADD and illegal_o=1;
  - the instruction is not multi-cycle.
- With valid_i=0 the block latches ADD, illegal_o=0, valid_o=0.
- FSM states: RUN and MC_WAIT. Counter width is $clog2(max(MUL_LATENCY,DIV_LATENCY)+1).
- RUN, stall_i=1: all output registers hold.
- RUN, stall_i=0:
  - Latch the decode, and set valid_o ← valid_i & ~flush_i.
  - If the latched op is a legal M op and valid: mdu_start_o ← 1 and cnt ← LAT−1.
  - Go to MC_WAIT if LAT > 1; otherwise stay in RUN.
- MC_WAIT:
  - Inputs, including flush_i, are ignored.
  - Output registers hold; mdu_start_o=0.
  - cnt decrements each cycle while non-zero.
  - At cnt=0 with stall_i=0, return to RUN; the next ID instruction is latched on that same edge.
  - At cnt=0 with stall_i=1, stay in MC_WAIT.
- busy_o = MC_WAIT & (cnt≠0 | stall_i), combinational from state.
- mc_done_o = MC_WAIT & cnt=0. When LAT=1 it equals the registered mdu_start_o.

## Timing
- Decode-to-output latency: one cycle.
- Multi-cycle op occupies EX for exactly LAT cycles when unstalled. busy_o is high for LAT−1 of them.
- Reset, taking priority over everything including mid-MC_WAIT:
  - state=RUN, cnt=0;
  - alu_operation_o=0, valid_o=0, illegal_o=0, mdu_start_o=0;
  - busy_o=0, mc_done_o=0.
- stall_i and the return to RUN can coincide; stall wins and the state holds.
- flush_i with stall_i=1 in RUN has no effect.

## Structure
- Shared package alu_ctrl_pkg holds:
  - ALU_Op class constants;
  - operation code localparams;
  - the FSM state enum.
- The register-transfer stage instantiates one combinational sub-module, alu_op_decode, which produces op, illegal and is_mul/is_div.

## Test plan
- SRA decode: funct7=0x20, alu_op=000, funct3=101, valid_i=1 → next cycle alu_operation_o=0x0C, valid_o=1, illegal_o=0, busy_o=0.
- DIV sequencing, DIV_LATENCY=4: funct7=0x01, alu_op=000, funct3=100.
  - Expect mdu_start_o=1 for one cycle and alu_operation_o=0x15.
  - busy_o stays high for 3 cycles, then mc_done_o=1 on the 4th.
  - The following ADD appears on the 5th cycle.
- Stall at completion, MUL_LATENCY=3: hold stall_i=1 from cycle 2 for 3 cycles.
  - mc_done_o and busy_o stay high.
  - The state leaves MC_WAIT on the first edge with stall_i=0.
- Flush in RUN: valid R ADD with flush_i=1 → valid_o=0 next cycle, no mdu_start_o.
- ENABLE_M=0, MUL encoding → alu_operation_o=0x00 and illegal_o=1; mdu_start_o and busy_o stay 0.
- Reset mid-operation: reset=0 during MC_WAIT with cnt=5 → next edge gives all outputs 0 and state RUN.
